lsp_expand_seq: RTL and testbench

//  Sequencer and scratch-memory arbiter for the G.729 LSP expand stage (Lsp_expand_1_2).

---
 rtl/lsp_expand_seq_if.sv | 12 +
 rtl/lsp_expand_seq.sv | 72 +++++++
 tb/tb_lsp_expand_seq.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/lsp_expand_seq_if.sv
// lsp_expand_seq_if: one scratch-memory port (read address, write address, write data, write enable)
interface lsp_expand_seq_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] readAddr;
  logic [ADDR_W-1:0] writeAddr;
  logic [DATA_W-1:0] data;
  logic              writeEn;
  modport master (output readAddr, writeAddr, data, writeEn);
  modport slave  (input  readAddr, writeAddr, data, writeEn);
endinterface

// File: rtl/lsp_expand_seq.sv
// lsp_expand_seq: runs LSP expand_1 then expand_2 and arbitrates the shared scratch port; LSP_EXP_TIMEOUT_EN adds a per-stage watchdog
module lsp_expand_seq #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             done,
  output logic             busy,
  output logic             exp1Start,
  input  logic             exp1Done,
  output logic             exp2Start,
  input  logic             exp2Done,
  lsp_expand_seq_if.slave  exp1Mem,
  lsp_expand_seq_if.slave  exp2Mem,
  lsp_expand_seq_if.master mem,
  output logic             timeoutErr
);
  typedef enum logic [2:0] {IDLE, START1, WAIT1, START2, WAIT2, DONE} stateT;
  stateT state, stateNext;
  logic grant1, grant2, timeoutHit;
  if (TIMEOUT_CYC < 2) begin : g_badTimeout
    $error("TIMEOUT_CYC must be at least 2");
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= stateNext;
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    stateNext = start ? START1 : IDLE;
      START1:  stateNext = WAIT1;
      WAIT1:   stateNext = exp1Done ? START2 : timeoutHit ? DONE : WAIT1;
      START2:  stateNext = WAIT2;
      WAIT2:   stateNext = exp2Done ? DONE : timeoutHit ? DONE : WAIT2;
      DONE:    stateNext = start ? START1 : DONE;
      default: stateNext = IDLE;
    endcase
  end
  assign done      = state == DONE;
  assign busy      = state != IDLE && state != DONE;
  assign exp1Start = state == START1;
  assign exp2Start = state == START2;
  assign grant1    = state == START1 || state == WAIT1;
  assign grant2    = state == START2 || state == WAIT2;
  assign mem.readAddr  = grant1 ? exp1Mem.readAddr  : grant2 ? exp2Mem.readAddr  : ADDR_W'(0);
  assign mem.writeAddr = grant1 ? exp1Mem.writeAddr : grant2 ? exp2Mem.writeAddr : ADDR_W'(0);
  assign mem.data      = grant1 ? exp1Mem.data      : grant2 ? exp2Mem.data      : DATA_W'(0);
  assign mem.writeEn   = grant1 ? exp1Mem.writeEn   : grant2 ? exp2Mem.writeEn   : 1'b0;
`ifdef LSP_EXP_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] waitCnt;
  logic inWait;
  assign inWait     = state == WAIT1 || state == WAIT2;
  // a done arriving on the last allowed cycle wins over the watchdog
  assign timeoutHit = waitCnt == CW'(TIMEOUT_CYC - 1) &&
                      ((state == WAIT1 && !exp1Done) || (state == WAIT2 && !exp2Done));
  always_ff @(posedge clk)
    if (reset) begin
      waitCnt    <= '0;
      timeoutErr <= 1'b0;
    end else begin
      waitCnt    <= inWait ? waitCnt + CW'(1) : '0;
      timeoutErr <= timeoutHit ? 1'b1 : stateNext == START1 ? 1'b0 : timeoutErr;
    end
`else
  assign timeoutHit = 1'b0;
  assign timeoutErr = 1'b0;
`endif
endmodule

// File: tb/tb_lsp_expand_seq.sv
// tb_lsp_expand_seq: randomized runs of the expand sequencer checked against a cycle-schedule model
module tb_lsp_expand_seq;
  localparam int AW = 11, DW = 32, TO = 16, MW = 2 * AW + DW + 1;
  logic clk = 1'b0;
  logic reset, start, done, busy, exp1Start, exp1Done, exp2Start, exp2Done, timeoutErr;
  logic [4:0] ctl;
  logic [MW-1:0] memV, e1V, e2V;
  logic clrMem = 1'b0;
  logic [DW-1:0] w0, w1;
  logic prevDone = 1'b0, prevErr = 1'b0;
  int nVec = 0, nErr = 0;
  always #5 clk = ~clk;
  lsp_expand_seq_if #(.ADDR_W(AW), .DATA_W(DW)) e1 ();
  lsp_expand_seq_if #(.ADDR_W(AW), .DATA_W(DW)) e2 ();
  lsp_expand_seq_if #(.ADDR_W(AW), .DATA_W(DW)) m ();
  lsp_expand_seq #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .busy(busy),
    .exp1Start(exp1Start), .exp1Done(exp1Done), .exp2Start(exp2Start), .exp2Done(exp2Done),
    .exp1Mem(e1), .exp2Mem(e2), .mem(m), .timeoutErr(timeoutErr)
  );
  assign ctl  = {done, busy, exp1Start, exp2Start, timeoutErr};
  assign memV = {m.readAddr, m.writeAddr, m.data, m.writeEn};
  assign e1V  = {e1.readAddr, e1.writeAddr, e1.data, e1.writeEn};
  assign e2V  = {e2.readAddr, e2.writeAddr, e2.data, e2.writeEn};
  // watch only the two addresses the directed write test targets
  always @(posedge clk)
    if (clrMem) begin
      w0 <= '0;
      w1 <= '0;
    end else if (m.writeEn) begin
      if (m.writeAddr == 11'h7F0) w0 <= m.data;
      if (m.writeAddr == 11'h7F1) w1 <= m.data;
    end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic randMem;
    e1.readAddr = AW'($urandom); e1.writeAddr = AW'($urandom); e1.data = $urandom; e1.writeEn = 1'($urandom);
    e2.readAddr = AW'($urandom); e2.writeAddr = AW'($urandom); e2.data = $urandom; e2.writeEn = 1'($urandom);
  endtask
  // Cycle 0 is the cycle start is driven; expand_1 owns the port in cycles 1..1+d1 and
  // expand_2 in 2+d1..2+d1+d2; done is expected from cycle 3+d1+d2.
  task automatic runOnce(input string name, input int d1, input int d2, input bit noise,
                         input bit dir, input int abortAt);
    int last;
    bit g1, g2, win1, win2;
    logic [4:0] eC;
    logic [MW-1:0] eM;
    last = 3 + d1 + d2;
    for (int c = 0; c <= last; c++) begin
      g1   = c >= 1 && c <= 1 + d1;
      g2   = c >= 2 + d1 && c <= 2 + d1 + d2;
      win1 = c >= 2 && c <= 1 + d1;
      win2 = c >= 3 + d1 && c <= 2 + d1 + d2;
      start    = c == 0 || (noise && c >= 1 && c < last && $urandom_range(3) == 0);
      exp1Done = c == 1 + d1 || (noise && !win1 && $urandom_range(3) == 0);
      exp2Done = c == 2 + d1 + d2 || (noise && !win2 && $urandom_range(3) == 0);
      reset    = c == abortAt;
      randMem();
      if (dir) begin
        e1.writeEn = g1 ? c == 2 : 1'b1;
        e1.writeAddr = g1 ? 11'h7F0 : 11'h7F1;
        e1.data = g1 ? 32'h1234 : 32'hBAD1;
        e2.writeEn = g2 ? c == 3 + d1 : 1'b1;
        e2.writeAddr = g2 ? 11'h7F1 : 11'h7F0;
        e2.data = g2 ? 32'h5678 : 32'hBAD2;
      end
      @(negedge clk);
      eC = {c == 0 ? prevDone : c == last, g1 || g2, c == 1, c == 2 + d1, c == 0 ? prevErr : 1'b0};
      eM = g1 ? e1V : g2 ? e2V : '0;
      nVec++;
      if (ctl !== eC) begin
        nErr++;
        $display("FAIL %s ctl c=%0d got=%b want=%b (done,busy,s1,s2,err)", name, c, ctl, eC);
      end
      nVec++;
      if (memV !== eM) begin
        nErr++;
        $display("FAIL %s mem c=%0d got=%h want=%h", name, c, memV, eM);
      end
      if (c == abortAt) break;
      tick();
    end
    prevDone = abortAt < 0;
    prevErr  = 1'b0;
  endtask
  task automatic test_reset;
    reset = 1'b1; start = 1'b1; exp1Done = 1'b1; exp2Done = 1'b1;
    randMem();
    tick(); tick();
    @(negedge clk);
    nVec++;
    if (ctl !== 5'b0 || memV !== '0) begin
      nErr++;
      $display("FAIL reset_hold ctl=%b mem=%h want 0", ctl, memV);
    end
    tick();
    reset = 1'b0; start = 1'b0; exp1Done = 1'b0; exp2Done = 1'b0;
    tick();
    @(negedge clk);
    nVec++;
    if (ctl !== 5'b0 || memV !== '0) begin
      nErr++;
      $display("FAIL reset_idle ctl=%b mem=%h want 0", ctl, memV);
    end
    tick();
    prevDone = 1'b0;
    prevErr = 1'b0;
  endtask
  task automatic test_basic;
    runOnce("basic", 5, 7, 1'b0, 1'b0, -1);
  endtask
  task automatic test_write_grant;
    start = 1'b0;
    clrMem = 1'b1;
    tick();
    clrMem = 1'b0;
    runOnce("write_grant", 3, 3, 1'b0, 1'b1, -1);
    nVec++;
    if (w0 !== 32'h1234 || w1 !== 32'h5678) begin
      nErr++;
      $display("FAIL write_grant_mem got 7F0=%h 7F1=%h want 1234 5678", w0, w1);
    end
  endtask
  task automatic test_ignore;
    for (int i = 0; i < 6; i++)
      runOnce("ignore", $urandom_range(12, 1), $urandom_range(12, 1), 1'b1, 1'b0, -1);
  endtask
  task automatic test_reset_mid;
    int d1, d2;
    d1 = $urandom_range(8, 1);
    d2 = $urandom_range(8, 2);
    runOnce("reset_mid", d1, d2, 1'b1, 1'b0, 3 + d1 + $urandom_range(d2 - 1));
    tick();
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    nVec++;
    if (ctl !== 5'b0 || memV !== '0) begin
      nErr++;
      $display("FAIL reset_mid_idle ctl=%b mem=%h want 0", ctl, memV);
    end
    tick();
    runOnce("after_reset", $urandom_range(6, 1), $urandom_range(6, 1), 1'b1, 1'b0, -1);
  endtask
  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      int h;
      h = $urandom_range(3);
      for (int j = 0; j < h; j++) begin
        start = 1'b0;
        exp1Done = 1'($urandom);
        exp2Done = 1'($urandom);
        randMem();
        @(negedge clk);
        nVec++;
        if (ctl !== 5'b10000 || memV !== '0) begin
          nErr++;
          $display("FAIL done_hold ctl=%b mem=%h want 10000 0", ctl, memV);
        end
        tick();
      end
      runOnce("back_to_back", $urandom_range(10, 1), $urandom_range(10, 1), 1'b1, 1'b0, -1);
    end
  endtask
  task automatic test_timeout;
`ifdef LSP_EXP_TIMEOUT_EN
    for (int c = 0; c <= 2 + TO; c++) begin
      start = c == 0;
      exp1Done = 1'b0;
      exp2Done = 1'($urandom);
      randMem();
      @(negedge clk);
      if (c == 1 + TO || c == 2 + TO) begin
        nVec++;
        if (ctl !== (c == 1 + TO ? 5'b01000 : 5'b10001)) begin
          nErr++;
          $display("FAIL timeout c=%0d got=%b want=%b", c, ctl, c == 1 + TO ? 5'b01000 : 5'b10001);
        end
      end
      tick();
    end
    prevDone = 1'b1;
    prevErr = 1'b1;
    runOnce("after_timeout", 4, 4, 1'b1, 1'b0, -1);
`else
    for (int c = 0; c <= 2 + 2 * TO; c++) begin
      start = c == 0;
      exp1Done = 1'b0;
      exp2Done = 1'($urandom);
      randMem();
      tick();
    end
    @(negedge clk);
    nVec++;
    if (ctl !== 5'b01000) begin
      nErr++;
      $display("FAIL no_timeout_hang got=%b want=01000", ctl);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    prevDone = 1'b0;
    prevErr = 1'b0;
    runOnce("after_hang", 2, 2, 1'b0, 1'b0, -1);
`endif
  endtask
  initial begin
    test_reset();
    test_basic();
    test_write_grant();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
